// File: rtl/shift_count_timer_if.sv
// shift_count_timer_if: control and status bundle between the command/host
// side (master) and the countdown timer (slave).
// Optional parallel-load signals appear when SHIFT_COUNT_TIMER_PLOAD_EN is defined.
interface shift_count_timer_if #(
    parameter int COUNT_W = 4
);
    logic               start;
    logic               data_in;
    logic               ack;
    logic               abort;
    logic               shifting;
    logic               counting;
    logic               done;
    logic               busy;
    logic [COUNT_W-1:0] count_out;
`ifdef SHIFT_COUNT_TIMER_PLOAD_EN
    logic               load;
    logic [COUNT_W-1:0] load_val;

    modport master (
        output start, data_in, ack, abort, load, load_val,
        input  shifting, counting, done, busy, count_out
    );

    modport slave (
        input  start, data_in, ack, abort, load, load_val,
        output shifting, counting, done, busy, count_out
    );
`else
    modport master (
        output start, data_in, ack, abort,
        input  shifting, counting, done, busy, count_out
    );

    modport slave (
        input  start, data_in, ack, abort,
        output shifting, counting, done, busy, count_out
    );
`endif
endinterface

// File: rtl/shift_count_timer.sv
// shift_count_timer: serial-programmed countdown timer.
// A start pulse shifts in a COUNT_W-bit delay MSB first, counts it down one
// unit every PRESCALE clocks, then holds done until the host acknowledges.
// Define SHIFT_COUNT_TIMER_PLOAD_EN to add a parallel load path from IDLE.
module shift_count_timer #(
    parameter int COUNT_W  = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    shift_count_timer_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = $clog2(COUNT_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COUNT,
        DONE
    } state_t;

    state_t             state_q,  state_d;
    logic [COUNT_W-1:0] delay_q,  delay_d;
    logic [BW-1:0]      bitCnt_q, bitCnt_d;
    logic [PW-1:0]      presc_q,  presc_d;

    logic               lastBit;
    logic               prescWrap;
    logic               loadReq;
    logic [COUNT_W-1:0] loadVal;

    assign lastBit   = (bitCnt_q == BW'(COUNT_W - 1));
    assign prescWrap = (presc_q == PW'(PRESCALE - 1));

`ifdef SHIFT_COUNT_TIMER_PLOAD_EN
    assign loadReq = bus.load;
    assign loadVal = bus.load_val;
`else
    assign loadReq = 1'b0;
    assign loadVal = '0;
`endif

    // State and datapath registers; reset asserts asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            delay_q  <= '0;
            bitCnt_q <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            bitCnt_q <= bitCnt_d;
            presc_q  <= presc_d;
        end
    end

    // Sequencer: abort overrides everything but leaves the delay value intact.
    always_comb begin
        state_d  = state_q;
        delay_d  = delay_q;
        bitCnt_d = bitCnt_q;
        presc_d  = presc_q;
        if (bus.abort) begin
            state_d  = IDLE;
            bitCnt_d = '0;
            presc_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (loadReq) begin
                        delay_d  = loadVal;
                        bitCnt_d = '0;
                        presc_d  = '0;
                        state_d  = COUNT;
                    end else if (bus.start) begin
                        bitCnt_d = '0;
                        presc_d  = '0;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    delay_d = {delay_q[COUNT_W-2:0], bus.data_in};
                    if (lastBit) begin
                        presc_d = '0;
                        state_d = COUNT;
                    end else begin
                        bitCnt_d = bitCnt_q + BW'(1);
                    end
                end
                COUNT: begin
                    if (prescWrap) begin
                        presc_d = '0;
                        if (delay_q != '0) begin
                            delay_d = delay_q - COUNT_W'(1);
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.shifting  = (state_q == SHIFT);
    assign bus.counting  = (state_q == COUNT);
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q == SHIFT) || (state_q == COUNT);
    assign bus.count_out = delay_q;

endmodule

// File: tb/tb_shift_count_timer.sv
// tb_shift_count_timer: self-checking bench for shift_count_timer with
// COUNT_W=4, PRESCALE=4. Expected done latencies go into a scoreboard queue
// when a sequence is launched and are popped when done is seen.
// Define SHIFT_COUNT_TIMER_PLOAD_EN to also exercise the parallel load path.
module tb_shift_count_timer;
    localparam int COUNT_W  = 4;
    localparam int PRESCALE = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    int   sbQ[$];

    shift_count_timer_if #(.COUNT_W(COUNT_W)) bus ();

    shift_count_timer #(
        .COUNT_W (COUNT_W),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic din, input logic ak, input logic ab);
        bus.start   = st;
        bus.data_in = din;
        bus.ack     = ak;
        bus.abort   = ab;
    endtask

    // Pulse start, then feed the delay MSB first; returns just after E_W.
    task automatic shiftIn(input logic [COUNT_W-1:0] bits);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = COUNT_W - 1; i >= 0; i--) begin
            applyStimulus(1'b0, bits[i], 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Count edges until done rises, bounded by limit.
    task automatic waitDone(input int limit, output int n, output bit timedOut);
        n = 0;
        timedOut = 1'b1;
        while (n < limit) begin
            tick();
            n++;
            if (bus.done === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic ackDone();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SHIFT_COUNT_TIMER_PLOAD_EN
        bus.load     = 1'b0;
        bus.load_val = '0;
`endif
        #12;
        checks++; if (bus.shifting !== 1'b0) begin failures++; $display("[TB] FAIL reset_shifting: got %b expected 0", bus.shifting); end
        checks++; if (bus.counting !== 1'b0) begin failures++; $display("[TB] FAIL reset_counting: got %b expected 0", bus.counting); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.count_out !== 4'b0000) begin failures++; $display("[TB] FAIL reset_count_out: got %b expected 0000", bus.count_out); end
        tick();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({bus.shifting, bus.counting, bus.done, bus.busy, bus.count_out} !== 8'h00) begin
                failures++;
                $display("[TB] FAIL idle_outputs cycle %0d: got %b expected 00000000", c,
                         {bus.shifting, bus.counting, bus.done, bus.busy, bus.count_out});
            end
        end
    endtask

    task automatic test_serial();
        int  n;
        int  expN;
        logic [3:0] bits;
        $display("[TB] test_serial");
        bits = 4'b1010;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if ({bus.shifting, bus.busy, bus.counting} !== 3'b110) begin failures++; $display("[TB] FAIL serial_shift_flags: got %b expected 110", {bus.shifting, bus.busy, bus.counting}); end
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b0, bits[i], 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        sbQ.push_back((10 + 1) * PRESCALE);
        checks++; if ({bus.shifting, bus.busy, bus.counting} !== 3'b011) begin failures++; $display("[TB] FAIL serial_count_flags: got %b expected 011", {bus.shifting, bus.busy, bus.counting}); end
        checks++; if (bus.count_out !== 4'b1010) begin failures++; $display("[TB] FAIL serial_loaded: got %b expected 1010", bus.count_out); end
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            if (bus.done === 1'b1) break;
            if ((n % PRESCALE) == 0 && n < 44) begin
                checks++;
                if (bus.count_out !== 4'(10 - n / PRESCALE)) begin
                    failures++;
                    $display("[TB] FAIL serial_decrement at %0d: got %0d expected %0d", n, bus.count_out, 10 - n / PRESCALE);
                end
            end
        end
        expN = sbQ.pop_front();
        checks++; if (n !== expN || bus.done !== 1'b1) begin failures++; $display("[TB] FAIL serial_done_latency: got %0d (done=%b) expected %0d", n, bus.done, expN); end
        checks++; if (bus.count_out !== 4'b0000) begin failures++; $display("[TB] FAIL serial_done_count: got %b expected 0000", bus.count_out); end
        tick();
        tick();
        checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL serial_done_hold: got %b expected 1", bus.done); end
        ackDone();
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin failures++; $display("[TB] FAIL serial_ack: got %b expected 00", {bus.done, bus.busy}); end
    endtask

    task automatic test_zero_delay();
        int n;
        int expN;
        bit to;
        $display("[TB] test_zero_delay");
        shiftIn(4'b0000);
        sbQ.push_back((0 + 1) * PRESCALE);
        checks++; if ({bus.counting, bus.count_out} !== 5'b1_0000) begin failures++; $display("[TB] FAIL zero_counting: got %b expected 10000", {bus.counting, bus.count_out}); end
        waitDone(20, n, to);
        expN = sbQ.pop_front();
        checks++; if (to || n !== expN) begin failures++; $display("[TB] FAIL zero_done_latency: got %0d (timeout=%b) expected %0d", n, to, expN); end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if ({bus.done, bus.shifting} !== 2'b10) begin failures++; $display("[TB] FAIL zero_start_ignored: got %b expected 10", {bus.done, bus.shifting}); end
        ackDone();
        checks++; if ({bus.done, bus.shifting} !== 2'b00) begin failures++; $display("[TB] FAIL zero_ack: got %b expected 00", {bus.done, bus.shifting}); end
    endtask

    task automatic test_abort_shift();
        $display("[TB] test_abort_shift");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if ({bus.shifting, bus.busy} !== 2'b00) begin failures++; $display("[TB] FAIL abort_shift_idle: got %b expected 00", {bus.shifting, bus.busy}); end
        checks++; if (bus.count_out !== 4'b0011) begin failures++; $display("[TB] FAIL abort_shift_keep: got %b expected 0011", bus.count_out); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if ({bus.done, bus.busy} !== 2'b00) begin failures++; $display("[TB] FAIL abort_shift_quiet cycle %0d: got %b expected 00", c, {bus.done, bus.busy}); end
        end
    endtask

    task automatic test_abort_count();
        $display("[TB] test_abort_count");
        shiftIn(4'b0010);
        for (int c = 0; c < 5; c++) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if ({bus.counting, bus.busy} !== 2'b00) begin failures++; $display("[TB] FAIL abort_count_idle: got %b expected 00", {bus.counting, bus.busy}); end
        checks++; if (bus.count_out !== 4'b0001) begin failures++; $display("[TB] FAIL abort_count_keep: got %b expected 0001", bus.count_out); end
        for (int c = 0; c < 16; c++) begin
            tick();
            checks++;
            if ({bus.done, bus.counting} !== 2'b00) begin failures++; $display("[TB] FAIL abort_count_quiet cycle %0d: got %b expected 00", c, {bus.done, bus.counting}); end
        end
    endtask

    task automatic test_reset_mid_count();
        $display("[TB] test_reset_mid_count");
        shiftIn(4'b0101);
        tick();
        tick();
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.counting, bus.busy} !== 2'b00) begin failures++; $display("[TB] FAIL async_reset_flags: got %b expected 00", {bus.counting, bus.busy}); end
        checks++; if (bus.count_out !== 4'b0000) begin failures++; $display("[TB] FAIL async_reset_count: got %b expected 0000", bus.count_out); end
        #1;
        reset_n = 1'b1;
        tick();
        checks++; if ({bus.shifting, bus.counting, bus.done, bus.busy, bus.count_out} !== 8'h00) begin failures++; $display("[TB] FAIL async_reset_release: got %b expected 00000000", {bus.shifting, bus.counting, bus.done, bus.busy, bus.count_out}); end
    endtask

    task automatic test_back_to_back();
        int n;
        int expN;
        bit to;
        $display("[TB] test_back_to_back");
        shiftIn(4'b0011);
        sbQ.push_back((3 + 1) * PRESCALE);
        waitDone(40, n, to);
        expN = sbQ.pop_front();
        checks++; if (to || n !== expN) begin failures++; $display("[TB] FAIL b2b_first_latency: got %0d (timeout=%b) expected %0d", n, to, expN); end
        ackDone();
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin failures++; $display("[TB] FAIL b2b_gap_idle: got %b expected 00", {bus.done, bus.busy}); end
        shiftIn(4'b0001);
        sbQ.push_back((1 + 1) * PRESCALE);
        checks++; if ({bus.counting, bus.count_out} !== 5'b1_0001) begin failures++; $display("[TB] FAIL b2b_second_loaded: got %b expected 10001", {bus.counting, bus.count_out}); end
        waitDone(40, n, to);
        expN = sbQ.pop_front();
        checks++; if (to || n !== expN) begin failures++; $display("[TB] FAIL b2b_second_latency: got %0d (timeout=%b) expected %0d", n, to, expN); end
        ackDone();
    endtask

`ifdef SHIFT_COUNT_TIMER_PLOAD_EN
    task automatic test_pload();
        int n;
        int expN;
        bit to;
        $display("[TB] test_pload");
        bus.load     = 1'b1;
        bus.load_val = 4'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.load = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        sbQ.push_back((2 + 1) * PRESCALE);
        checks++; if ({bus.counting, bus.shifting, bus.count_out} !== 6'b10_0010) begin failures++; $display("[TB] FAIL pload_direct: got %b expected 100010", {bus.counting, bus.shifting, bus.count_out}); end
        waitDone(40, n, to);
        expN = sbQ.pop_front();
        checks++; if (to || n !== expN) begin failures++; $display("[TB] FAIL pload_latency: got %0d (timeout=%b) expected %0d", n, to, expN); end
        ackDone();
    endtask
`endif

    // Scenario sequence and final summary.
    initial begin
        test_reset();
        test_serial();
        test_zero_delay();
        test_abort_shift();
        test_abort_count();
        test_reset_mid_count();
        test_back_to_back();
`ifdef SHIFT_COUNT_TIMER_PLOAD_EN
        test_pload();
`endif
        checks++; if (sbQ.size() !== 0) begin failures++; $display("[TB] FAIL scoreboard_drain: got %0d expected 0", sbQ.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/shift_count_timer.md
# shift_count_timer

Parametrised serial-programmed countdown timer, the next-generation replacement for the fixed 8-bit shift / 4-bit count datapath. A `start` pulse launches a sequencer that serially shifts in a COUNT_W-bit delay MSB first, then counts it down with a PRESCALE-cycle tick. It raises `done` until acknowledged. The block sits beside the command decoder that supplies `start`/`data_in` and the host logic that consumes `done`/`ack`.

## Interface
- COUNT_W, 4, delay/count width in bits; legal range ≥ 2.
- PRESCALE, 1000, clock cycles per count unit; legal range ≥ 1. Prescaler width is max(1, $clog2(PRESCALE)).

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset; one clock domain; asynchronous assert; release is synchronous to `clk` upstream.
- start  in  1  begin a sequence; sampled only in IDLE.
- data_in  in  1  serial delay bit; sampled only in SHIFT.
- ack  in  1  acknowledge `done`; sampled only in DONE.
- abort  in  1  synchronous cancel; return to IDLE from any state.
- shifting  out  1  high in SHIFT.
- counting  out  1  high in COUNT.
- done  out  1  high in DONE.
- busy  out  1  high in SHIFT or COUNT.
- count_out  out  COUNT_W  current delay register value, in every state.

## Operation
- States: IDLE, SHIFT, COUNT, DONE. Outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.
- IDLE, start=1: go to SHIFT. Clear the bit counter and prescaler. `delay_reg` holds its value until the first shift.
- SHIFT: each cycle, `delay_reg <= {delay_reg[COUNT_W-2:0], data_in}`. After COUNT_W shifts, go to COUNT with prescaler = 0.
- COUNT: the prescaler increments every cycle.
  - At PRESCALE-1 with delay_reg ≠ 0: decrement delay_reg and clear the prescaler.
  - At PRESCALE-1 with delay_reg = 0: go to DONE.
  - delay_reg never wraps below 0.
- DONE: `done` stays high, and `count_out` = 0, until ack=1; then go to IDLE. `start` is ignored in DONE.
- Priority, highest first: reset_n=0, abort, then normal transitions.
  - abort forces IDLE on the next edge and clears the prescaler and bit counter.
  - abort leaves delay_reg unchanged.
- Delay D = 0 is legal and gives exactly PRESCALE counting cycles.
- Reset: state IDLE and all registers 0. All outputs are 0: shifting, counting, done, busy, count_out.

## Timing
- Edge E0 samples start=1. data_in is sampled at edges E1..E_W, where W = COUNT_W, MSB first.
- shifting is high after E0 through E_W. counting rises after E_W.
- done rises after edge E_W + (D+1)·PRESCALE and stays high for at least 1 cycle.
- ack sampled high at edge E_A: done falls after E_A, and start is accepted from edge E_A+1 onward.
- Back-to-back sequences therefore have a 1-cycle minimum gap in IDLE.
- Asserting reset_n mid-sequence clears state immediately, without waiting for an edge.

## Configuration
- SHIFT_COUNT_TIMER_PLOAD_EN defined: adds ports `load` (in, 1) and `load_val` (in, COUNT_W).
  - In IDLE, load=1 copies load_val into delay_reg and goes straight to COUNT, skipping SHIFT. Timing is as above with E_W replaced by the load edge.
  - load=1 and start=1 together: load wins.
- Not defined: the ports are absent, and delay is programmable only serially.

## Test plan
Bench parameters: COUNT_W=4, PRESCALE=4.
- Reset → all outputs 0, state IDLE. Release reset, hold start=0 for 10 cycles → outputs stay 0.
- start at E0, data_in 1,0,1,0 at E1..E4 → count_out=4'b1010 after E4; count_out decrements every 4 cycles; done rises after edge E4+44 and holds until ack; ack → IDLE.
- Serial delay 0000 → done rises exactly 4 cycles after counting rises; start pulsed while done=1 is ignored.
- abort asserted during SHIFT (after E2) and separately during COUNT → IDLE on the next edge, busy=0, no done. Assert reset_n=0 mid-COUNT → outputs 0 asynchronously.
- Two back-to-back sequences with delays 0011 and 0001 (start one cycle after ack) → done after 16 and 8 counting cycles respectively.
- With SHIFT_COUNT_TIMER_PLOAD_EN: load=1, load_val=2, start=1 in the same cycle → COUNT next edge (no SHIFT) and done after 12 counting cycles.
